posit_unpack_stage: RTL and testbench



---
 rtl/posit_unpack_stage_pkg.sv | 22 ++
 rtl/posit_unpack_stage_regime_lzd.sv | 25 ++
 rtl/posit_unpack_stage.sv | 137 +++++++++++++
 tb/tb_posit_unpack_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_unpack_stage_pkg.sv
// Shared posit types and widths for the PairHMM posit datapath.
package posit_pkg;

  localparam int unsigned N  = 32;
  localparam int unsigned ES = 2;
  localparam int unsigned SW = $clog2(N) + ES + 1;
  localparam int unsigned FW = N - ES - 2;
  localparam int unsigned MW = $clog2(N);

  typedef logic [N-1:0] posit_t;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } posit_unpacked_t;

  localparam posit_t NAR = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/posit_unpack_stage_regime_lzd.sv
// Regime run detector: length and polarity of the leading run in a posit magnitude.
module posit_regime_lzd
  import posit_pkg::*;
(
  input  logic [N-2:0]  i_magnitude,
  output logic [MW-1:0] o_m,
  output logic          o_polarity
);

  logic w_done;

  always_comb begin
    o_polarity = i_magnitude[N-2];
    o_m        = '0;
    w_done     = 1'b0;
    for (int unsigned i = 0; i < N-1; i++) begin
      if (!w_done && (i_magnitude[N-2-i] == o_polarity)) begin
        o_m = o_m + 1'b1;
      end else begin
        w_done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_unpack_stage.sv
// Two-stage posit unpacker (sign/zero/NaR/scale/fraction) with valid/ready backpressure.
// Optional tag sideband enabled by `define POSIT_UNPACK_TAG_EN.
module posit_unpack_stage
  import posit_pkg::*;
`ifdef POSIT_UNPACK_TAG_EN
#(
  parameter int unsigned TAG_W = 8
)
`endif
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_posit,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef POSIT_UNPACK_TAG_EN
  input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]     out_tag,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_inf,
  output logic signed [SW-1:0] out_scale,
  output logic [FW-1:0]        out_frac
);

  logic            r_s1_valid;
  logic            r_s1_sign;
  logic            r_s1_zero;
  logic            r_s1_inf;
  logic [N-2:0]    r_s1_mag;
  logic            r_out_valid;
  posit_unpacked_t r_out;

  logic            w_s2_adv;
  logic            w_in_ready;
  logic [N-2:0]    w_mag;
  logic [MW-1:0]   w_m;
  logic            w_pol;
  logic [N-4:0]    w_rem;
  logic [SW-1:0]   w_mext;
  logic [SW-1:0]   w_k;
  logic [ES-1:0]   w_e;
  posit_unpacked_t w_dec;

  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_in_ready = !reset && (!r_s1_valid || w_s2_adv);
  assign in_ready   = w_in_ready;

  // Only the low N-1 bits of the negation are needed; they match -x mod 2^(N-1).
  assign w_mag = in_posit[N-1] ? (~in_posit[N-2:0] + 1'b1) : in_posit[N-2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_mag   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_posit[N-1];
        r_s1_zero <= (in_posit == '0);
        r_s1_inf  <= (in_posit == NAR);
        r_s1_mag  <= w_mag;
      end
    end
  end

  posit_regime_lzd u_lzd (
    .i_magnitude (r_s1_mag),
    .o_m         (w_m),
    .o_polarity  (w_pol)
  );

  // The regime plus terminator spans m+1 bits and m>=1, so bits below the
  // shortest regime shifted by m-1 leave exponent then fraction left-aligned.
  assign w_rem  = r_s1_mag[N-4:0] << (w_m - 1'b1);
  assign w_e    = w_rem[N-4 -: ES];
  assign w_mext = SW'(w_m);
  assign w_k    = w_pol ? (w_mext - 1'b1) : ('0 - w_mext);

  always_comb begin
    w_dec      = '0;
    w_dec.sign = r_s1_sign;
    w_dec.zero = r_s1_zero;
    w_dec.inf  = r_s1_inf;
    if (!r_s1_zero && !r_s1_inf) begin
      w_dec.scale = $signed((w_k << ES) | SW'(w_e));
      w_dec.frac  = {1'b1, w_rem[FW-2:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_dec;
      end
    end
  end

`ifdef POSIT_UNPACK_TAG_EN
  logic [TAG_W-1:0] r_s1_tag;
  logic [TAG_W-1:0] r_out_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_tag  <= '0;
      r_out_tag <= '0;
    end else begin
      if (w_in_ready && in_valid) begin
        r_s1_tag <= in_tag;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_out_tag <= r_s1_tag;
      end
    end
  end

  assign out_tag = r_out_tag;
`endif

  assign out_valid = r_out_valid;
  assign out_sign  = r_out.sign;
  assign out_zero  = r_out.zero;
  assign out_inf   = r_out.inf;
  assign out_scale = r_out.scale;
  assign out_frac  = r_out.frac;

endmodule

// File: tb/tb_posit_unpack_stage.sv
// Scoreboard bench for posit_unpack_stage; build with +define+POSIT_UNPACK_TAG_EN to cover tags.
module tb_posit_unpack_stage;
  import posit_pkg::*;

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          inf;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
    logic [7:0]    tag;
  } exp_t;

`ifdef POSIT_UNPACK_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         in_posit;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_inf;
  logic signed [SW-1:0] out_scale;
  logic [FW-1:0]        out_frac;
  logic [7:0]           tag_in;
  logic [7:0]           tag_out;

  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   total_waits = 0;
  bit   saw_in_ready_low = 1'b0;
  bit   stall_pending = 1'b0;
  exp_t stall_snap;
  exp_t sb[$];

  always #5 clk = ~clk;

  posit_unpack_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_posit  (in_posit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef POSIT_UNPACK_TAG_EN
    .in_tag    (tag_in),
    .out_tag   (tag_out),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_inf   (out_inf),
    .out_scale (out_scale),
    .out_frac  (out_frac)
  );

`ifndef POSIT_UNPACK_TAG_EN
  assign tag_out = tag_in & 8'h00;
`endif

  function automatic exp_t mk(bit s, bit z, bit f_inf, int sc, int fr, logic [7:0] t);
    exp_t r;
    r.sign  = s;
    r.zero  = z;
    r.inf   = f_inf;
    r.scale = SW'(sc);
    r.frac  = FW'(fr);
    r.tag   = TAG_EN ? t : 8'h00;
    return r;
  endfunction

  // Bit-serial reference decoder.
  function automatic exp_t model(logic [N-1:0] p, logic [7:0] t);
    exp_t          r;
    logic [N-1:0]  mag;
    logic          rb;
    logic [FW-1:0] f;
    int            i;
    int            run;
    int            k;
    int            e;
    r     = '0;
    r.tag = TAG_EN ? t : 8'h00;
    if (p == '0) begin
      r.zero = 1'b1;
      return r;
    end
    if (p == NAR) begin
      r.inf  = 1'b1;
      r.sign = 1'b1;
      return r;
    end
    r.sign = p[N-1];
    mag    = p[N-1] ? (~p + 1) : p;
    rb     = mag[N-2];
    i      = N - 2;
    run    = 0;
    while (i >= 0 && mag[i] == rb) begin
      run++;
      i--;
    end
    k = rb ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? int'(mag[i]) : 0);
      i--;
    end
    f = FW'(1);
    for (int j = 0; j < FW - 1; j++) begin
      f = {f[FW-2:0], ((i >= 0) ? mag[i] : 1'b0)};
      i--;
    end
    r.scale = SW'(k * (1 << ES) + e);
    r.frac  = f;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_exp(input logic [N-1:0] p, input logic [7:0] t, input exp_t ex);
    int w;
    w        = 0;
    in_posit = p;
    tag_in   = t;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    total_waits += w;
    checks++;
    assert (w < 100) else begin
      errors++;
      $error("FAIL accept_timeout posit=%h waited=%0d required<100", p, w);
    end
    sb.push_back(ex);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] p, input logic [7:0] t);
    send_exp(p, t, model(p, t));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t obs;
    exp_t ex;
    #2;
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      obs.sign  = out_sign;
      obs.zero  = out_zero;
      obs.inf   = out_inf;
      obs.scale = out_scale;
      obs.frac  = out_frac;
      obs.tag   = tag_out;
      if (stall_pending) begin
        checks++;
        assert (obs === stall_snap) else begin
          errors++;
          $error("FAIL stall_hold got=%h required=%h", obs, stall_snap);
        end
      end
      stall_pending = 1'b0;
      if (out_valid && !out_ready) begin
        stall_pending = 1'b1;
        stall_snap    = obs;
      end
      if (!in_ready) saw_in_ready_low = 1'b1;
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output got=%h required=none", obs);
          end
        end else begin
          ex = sb.pop_front();
          assert (obs === ex) else begin
            errors++;
            $error("FAIL output got=%h required=%h", obs, ex);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_posit  = '0;
    tag_in    = 8'h00;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    checks++;
    assert ({out_valid, out_sign, out_zero, out_inf, out_scale, out_frac} === '0) else begin
      errors++;
      $error("FAIL reset_outputs got=%h required=0",
             {out_valid, out_sign, out_zero, out_inf, out_scale, out_frac});
    end
    checks++;
    assert (in_ready === 1'b0) else begin
      errors++;
      $error("FAIL reset_in_ready got=%b required=0", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;

    // Latency: accepted before posedge P1, out_valid visible after P2.
    send_exp(32'h4000_0000, 8'h01, mk(0, 0, 0, 0, 28'h800_0000, 8'h01));
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      errors++;
      $error("FAIL latency_early got=%b required=0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    assert (out_valid === 1'b1) else begin
      errors++;
      $error("FAIL latency_two got=%b required=1", out_valid);
    end
    @(negedge clk);
    wait_drain();

    send_exp(32'h4400_0000, 8'h02, mk(0, 0, 0, 0, 28'hC00_0000, 8'h02));
    send_exp(32'h4800_0000, 8'h03, mk(0, 0, 0, 1, 28'h800_0000, 8'h03));
    send_exp(32'hC000_0000, 8'h04, mk(1, 0, 0, 0, 28'h800_0000, 8'h04));
    send_exp(32'h7FFF_FFFF, 8'h05, mk(0, 0, 0, 120, 28'h800_0000, 8'h05));
    send_exp(32'h0000_0001, 8'h06, mk(0, 0, 0, -120, 28'h800_0000, 8'h06));
    send_exp(32'h0000_0000, 8'h07, mk(0, 1, 0, 0, 0, 8'h07));
    send_exp(32'h8000_0000, 8'h08, mk(1, 0, 1, 0, 0, 8'h08));
    send(32'h8000_0001, 8'h09);
    send(32'h3FFF_FFFF, 8'h0A);
    wait_drain();

    // Full rate: no acceptance wait with the consumer always ready.
    total_waits = 0;
    for (int i = 0; i < 16; i++) send($urandom(), 8'(8'h30 + i));
    checks++;
    assert (total_waits == 0) else begin
      errors++;
      $error("FAIL full_rate waits=%0d required=0", total_waits);
    end
    wait_drain();

    // Backpressure: consumer stalls for four cycles during an eight-item burst.
    saw_in_ready_low = 1'b0;
    n_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom(), 8'(8'h11 + i));
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    assert (saw_in_ready_low === 1'b1) else begin
      errors++;
      $error("FAIL bp_in_ready_drop got=%b required=1", saw_in_ready_low);
    end
    checks++;
    assert (n_out - n_before == 8) else begin
      errors++;
      $error("FAIL bp_count got=%0d required=8", n_out - n_before);
    end

    // Reset with two items in flight.
    out_ready = 1'b0;
    send($urandom(), 8'h21);
    send($urandom(), 8'h22);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    assert (out_valid === 1'b0 && in_ready === 1'b0) else begin
      errors++;
      $error("FAIL async_reset out_valid=%b in_ready=%b required=0,0", out_valid, in_ready);
    end
    sb.delete();
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      errors++;
      $error("FAIL stale_after_reset got=%b required=0", out_valid);
    end
    @(negedge clk);
    send_exp(32'h4800_0000, 8'h33, mk(0, 0, 0, 1, 28'h800_0000, 8'h33));
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
